sobel_window_feeder: RTL and testbench

Upstream neighbour of the Sobel control stage. It buffers the raster grayscale stream from the RGB-to-gray converter in a three-row line buffer. It then replays each row band as the serial 3×3 window sequence the Sobel stage consumes, framed by `start_o`/`finish_o` pulses. Its outputs drive the Sobel stage's start, finish and gray-pixel inputs directly.

---
 rtl/sobel_window_feeder_pkg.sv | 34 +++
 rtl/sobel_line_buffer.sv | 35 +++
 rtl/sobel_window_feeder.sv | 233 +++++++++++++++++++++++
 tb/tb_sobel_window_feeder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_window_feeder_pkg.sv
// Shared definitions for the Sobel window feeder.
// - Default pixel width and maximum image dimensions, plus derived bit widths.
// - feeder_state_t: emission/fill sequencer states.
// - row_add(): circular (mod 3) row arithmetic for the line-buffer head pointer.
package sobel_window_feeder_pkg;

  localparam int DEF_PIXEL_WIDTH = 8;
  localparam int DEF_MAX_WIDTH   = 640;
  localparam int DEF_MAX_HEIGHT  = 480;
  localparam int DEF_WIDTH_W     = $clog2(DEF_MAX_WIDTH + 1);
  localparam int DEF_HEIGHT_W    = $clog2(DEF_MAX_HEIGHT + 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FILL,
    ST_START,
    ST_FIRST_WIN,
    ST_GAP,
    ST_COLUMN,
    ST_FINISH,
    ST_BAND_IDLE,
    ST_LOAD_ROW,
    ST_DONE
  } feeder_state_t;

  // (base + off) mod 3, both operands in 0..2
  function automatic logic [1:0] row_add(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= 3'd3) sum = sum - 3'd3;
    return sum[1:0];
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Three-row line buffer for the Sobel window feeder.
// Ports:
//   clk_i                 write clock
//   we_i, wr_row_i,
//   wr_col_i, wr_data_i   synchronous write port
//   rd_row_i, rd_col_i    combinational read address
//   rd_data_o             read data (0 for the unused row code 3)
// Contents are not reset; every row is written before it is read.
module sobel_line_buffer #(
  parameter int PIXEL_WIDTH = 8,
  parameter int MAX_WIDTH   = 640,
  parameter int COL_W       = $clog2(MAX_WIDTH)
) (
  input  logic                   clk_i,
  input  logic                   we_i,
  input  logic [1:0]             wr_row_i,
  input  logic [COL_W-1:0]       wr_col_i,
  input  logic [PIXEL_WIDTH-1:0] wr_data_i,
  input  logic [1:0]             rd_row_i,
  input  logic [COL_W-1:0]       rd_col_i,
  output logic [PIXEL_WIDTH-1:0] rd_data_o
);

  logic [PIXEL_WIDTH-1:0] mem_q [3][MAX_WIDTH];

  always_ff @(posedge clk_i) begin
    if (we_i && (wr_row_i != 2'd3)) mem_q[wr_row_i][wr_col_i] <= wr_data_i;
  end

  always_comb begin
    rd_data_o = '0;
    if (rd_row_i != 2'd3) rd_data_o = mem_q[rd_row_i][rd_col_i];
  end

endmodule

// File: rtl/sobel_window_feeder.sv
// Sobel window feeder: buffers a raster gray stream in three rows and replays
// each row band as the serial 3x3 window sequence (top, mid, bottom per column).
// Ports:
//   clk_i, reset_i            clock, async active-high reset
//   frame_start_i             latch img_width_i/img_height_i and begin a frame
//   px_gray_i/px_valid_i      raster input, accepted when px_ready_o is high
//   start_o/finish_o          band framing pulses
//   px_gray_o                 window pixel (0 on non-data cycles)
//   busy_o, frame_done_o      frame status
// All outputs are flops loaded from the next-state decode, so each output
// reflects the state the FSM is in during that cycle.
module sobel_window_feeder
  import sobel_window_feeder_pkg::*;
#(
  parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int MAX_WIDTH   = DEF_MAX_WIDTH,
  parameter int MAX_HEIGHT  = DEF_MAX_HEIGHT
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             frame_start_i,
  input  logic [$clog2(MAX_WIDTH+1)-1:0]   img_width_i,
  input  logic [$clog2(MAX_HEIGHT+1)-1:0]  img_height_i,
  input  logic [PIXEL_WIDTH-1:0]           px_gray_i,
  input  logic                             px_valid_i,
  output logic                             px_ready_o,
  output logic                             start_o,
  output logic                             finish_o,
  output logic [PIXEL_WIDTH-1:0]           px_gray_o,
  output logic                             busy_o,
  output logic                             frame_done_o
);

  localparam int WW = $clog2(MAX_WIDTH + 1);
  localparam int HW = $clog2(MAX_HEIGHT + 1);
  localparam int CW = $clog2(MAX_WIDTH);

  feeder_state_t state_q, state_d;
  logic [WW-1:0] w_q, w_d, col_q, col_d;
  logic [HW-1:0] h_q, h_d, band_q, band_d;
  logic [1:0]    sub_q, sub_d;    // row within the current window column
  logic [1:0]    fill_q, fill_d;  // physical row being filled during FILL
  logic [1:0]    head_q, head_d;  // physical row holding the oldest (top) row

  logic                   ready_q, start_q, finish_q, busy_q, done_q;
  logic [PIXEL_WIDTH-1:0] gray_q, gray_d;

  logic                   xfer, we;
  logic [1:0]             wr_row, rd_row;
  logic [PIXEL_WIDTH-1:0] rd_data;
  logic                   emit_d;

  assign xfer = px_ready_o && px_valid_i;
  assign we   = xfer;
  assign wr_row = (state_q == ST_FILL) ? fill_q : head_q;
  assign rd_row = row_add(head_d, sub_d);
  assign emit_d = (state_d == ST_FIRST_WIN) || (state_d == ST_COLUMN);

  sobel_line_buffer #(
    .PIXEL_WIDTH(PIXEL_WIDTH),
    .MAX_WIDTH  (MAX_WIDTH),
    .COL_W      (CW)
  ) u_lb (
    .clk_i    (clk_i),
    .we_i     (we),
    .wr_row_i (wr_row),
    .wr_col_i (col_q[CW-1:0]),
    .wr_data_i(px_gray_i),
    .rd_row_i (rd_row),
    .rd_col_i (col_d[CW-1:0]),
    .rd_data_o(rd_data)
  );

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    col_d   = col_q;
    sub_d   = sub_q;
    fill_d  = fill_q;
    band_d  = band_q;
    head_d  = head_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_start_i) begin
          w_d    = img_width_i;
          h_d    = img_height_i;
          col_d  = '0;
          sub_d  = '0;
          fill_d = '0;
          band_d = '0;
          head_d = '0;
          if ((img_width_i < WW'(3)) || (img_height_i < HW'(3))) state_d = ST_DONE;
          else state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (xfer) begin
          if (col_q == w_q - WW'(1)) begin
            col_d = '0;
            if (fill_q == 2'd2) begin
              fill_d  = '0;
              state_d = ST_START;
            end else begin
              fill_d = fill_q + 2'd1;
            end
          end else begin
            col_d = col_q + WW'(1);
          end
        end
      end
      ST_START: begin
        col_d   = '0;
        sub_d   = '0;
        state_d = ST_FIRST_WIN;
      end
      ST_FIRST_WIN: begin
        if (sub_q == 2'd2) begin
          sub_d = '0;
          if (col_q == WW'(2)) begin
            if (w_q == WW'(3)) begin
              col_d   = '0;
              state_d = ST_FINISH;
            end else begin
              col_d   = WW'(3);
              state_d = ST_GAP;
            end
          end else begin
            col_d = col_q + WW'(1);
          end
        end else begin
          sub_d = sub_q + 2'd1;
        end
      end
      ST_GAP: begin
        sub_d   = '0;
        state_d = ST_COLUMN;
      end
      ST_COLUMN: begin
        if (sub_q == 2'd2) begin
          sub_d = '0;
          if (col_q == w_q - WW'(1)) begin
            col_d   = '0;
            state_d = ST_FINISH;
          end else begin
            col_d   = col_q + WW'(1);
            state_d = ST_GAP;
          end
        end else begin
          sub_d = sub_q + 2'd1;
        end
      end
      ST_FINISH: state_d = ST_BAND_IDLE;
      ST_BAND_IDLE: begin
        if (band_q == h_q - HW'(3)) begin
          state_d = ST_DONE;
        end else begin
          band_d  = band_q + HW'(1);
          col_d   = '0;
          state_d = ST_LOAD_ROW;
        end
      end
      ST_LOAD_ROW: begin
        // The oldest row is overwritten; once full it becomes the bottom row.
        if (xfer) begin
          if (col_q == w_q - WW'(1)) begin
            col_d   = '0;
            head_d  = row_add(head_q, 2'd1);
            state_d = ST_START;
          end else begin
            col_d = col_q + WW'(1);
          end
        end
      end
      ST_DONE: begin
        col_d   = '0;
        sub_d   = '0;
        fill_d  = '0;
        band_d  = '0;
        head_d  = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gray_d = '0;
    if (emit_d) gray_d = rd_data;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      w_q      <= '0;
      h_q      <= '0;
      col_q    <= '0;
      sub_q    <= '0;
      fill_q   <= '0;
      band_q   <= '0;
      head_q   <= '0;
      ready_q  <= 1'b0;
      start_q  <= 1'b0;
      finish_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      gray_q   <= '0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      h_q      <= h_d;
      col_q    <= col_d;
      sub_q    <= sub_d;
      fill_q   <= fill_d;
      band_q   <= band_d;
      head_q   <= head_d;
      ready_q  <= (state_d == ST_FILL) || (state_d == ST_LOAD_ROW);
      start_q  <= (state_d == ST_START);
      finish_q <= (state_d == ST_FINISH);
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_d == ST_DONE);
      gray_q   <= gray_d;
    end
  end

  assign px_ready_o   = ready_q;
  assign start_o      = start_q;
  assign finish_o     = finish_q;
  assign px_gray_o    = gray_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_sobel_window_feeder.sv
// Bench for sobel_window_feeder: random/directed frames, a cycle-level model
// derived from the band timing formulas, and literal sequence checks.
module tb_sobel_window_feeder;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       frame_start_i = 1'b0;
  logic [9:0] img_width_i = '0;
  logic [8:0] img_height_i = '0;
  logic [7:0] px_gray_i = '0;
  logic       px_valid_i = 1'b0;
  logic       px_ready_o, start_o, finish_o, busy_o, frame_done_o;
  logic [7:0] px_gray_o;

  sobel_window_feeder dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .frame_start_i(frame_start_i),
    .img_width_i  (img_width_i),
    .img_height_i (img_height_i),
    .px_gray_i    (px_gray_i),
    .px_valid_i   (px_valid_i),
    .px_ready_o   (px_ready_o),
    .start_o      (start_o),
    .finish_o     (finish_o),
    .px_gray_o    (px_gray_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [7:0] img [0:15][0:15];

  int e33 [9]  = '{1, 4, 7, 2, 5, 8, 3, 6, 9};
  int e43 [12] = '{0, 10, 20, 1, 11, 21, 2, 12, 22, 3, 13, 23};
  int e44 [12] = '{10, 20, 30, 11, 21, 31, 12, 22, 32, 13, 23, 33};

  // ---------------- model + compare process ----------------
  localparam int M_IDLE = 0, M_FILL = 1, M_EMIT = 2, M_DONE = 3;
  int mode = M_IDLE;
  int mW, mH, need, acc, band, t;
  int cyc_n = 0;
  int n_start = 0, n_fin = 0, n_done = 0;
  int st_cyc = 0, fin_cyc = 0, fs_cyc = 0, done_cyc = 0;
  int cap [$];

  always @(negedge clk) begin
    int e_start, e_fin, e_gray, e_ready, e_busy, e_done, dat, len, k, u;
    cyc_n++;
    if (start_o)      begin n_start++; st_cyc = cyc_n; end
    if (finish_o)     begin n_fin++; fin_cyc = cyc_n; end
    if (frame_done_o) begin n_done++; done_cyc = cyc_n; end
    if (frame_start_i) fs_cyc = cyc_n;
    if (reset_i) begin
      chk("rst_start", start_o, 0);
      chk("rst_finish", finish_o, 0);
      chk("rst_gray", px_gray_o, 0);
      chk("rst_ready", px_ready_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", frame_done_o, 0);
      mode = M_IDLE;
    end else begin
      e_start = 0; e_fin = 0; e_gray = 0; e_ready = 0; e_busy = 0; e_done = 0; dat = 0;
      len = 11 + 4 * (mW - 3);
      case (mode)
        M_FILL: begin e_ready = 1; e_busy = 1; end
        M_EMIT: begin
          e_busy = 1;
          if (t == 0) e_start = 1;
          else if (t <= 9) begin
            k = t - 1; dat = 1; e_gray = img[band + k % 3][k / 3];
          end else if (t == len - 1) e_fin = 1;
          else if (t < len - 1) begin
            u = t - 10;
            if (u % 4 != 0) begin dat = 1; e_gray = img[band + u % 4 - 1][3 + u / 4]; end
          end
        end
        M_DONE: begin e_done = 1; e_busy = 1; end
        default: ;
      endcase
      chk("start_o", start_o, e_start);
      chk("finish_o", finish_o, e_fin);
      chk("px_gray_o", px_gray_o, e_gray);
      chk("px_ready_o", px_ready_o, e_ready);
      chk("busy_o", busy_o, e_busy);
      chk("frame_done_o", frame_done_o, e_done);
      if (dat != 0) cap.push_back(int'(px_gray_o));
      case (mode)
        M_IDLE: if (frame_start_i) begin
          mW = int'(img_width_i); mH = int'(img_height_i);
          band = 0; acc = 0; need = 3 * mW;
          mode = (mW < 3 || mH < 3) ? M_DONE : M_FILL;
        end
        M_FILL: if (px_valid_i) begin
          acc++;
          if (acc == need) begin mode = M_EMIT; t = 0; end
        end
        M_EMIT: begin
          if (t == len) begin
            if (band == mH - 3) mode = M_DONE;
            else begin band++; acc = 0; need = mW; mode = M_FILL; end
          end else t++;
        end
        default: mode = M_IDLE;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_img(input int w, input int h, input int kind);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        case (kind)
          0: img[r][c] = 8'(r * w + c + 1);
          1: img[r][c] = 8'(10 * r + c);
          default: img[r][c] = 8'($urandom_range(0, 255));
        endcase
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      px_valid_i = 1'b1;
      px_gray_i = 8'($urandom_range(0, 255));
    end
    @(posedge clk); #1;
    px_valid_i = 1'b0;
  endtask

  task automatic run_frame(input int w, input int h, input int vmode,
                           input int rst_after, input bit spur);
    int pi, cyc, since;
    bit xfer, finished, v;
    @(posedge clk); #1;
    frame_start_i = 1'b1; img_width_i = 10'(w); img_height_i = 9'(h); px_valid_i = 1'b0;
    @(posedge clk); #1;
    frame_start_i = 1'b0;
    pi = 0; cyc = 0; since = -1; finished = 0;
    while (!finished && cyc < 5000) begin
      case (vmode)
        0: v = 1'b1;
        1: v = cyc[0];
        default: v = 1'($urandom_range(0, 1));
      endcase
      px_valid_i = (pi < w * h) ? v : 1'b0;
      px_gray_i = (pi < w * h) ? img[pi / w][pi % w] : 8'd0;
      frame_start_i = spur && ($urandom_range(0, 7) == 0);
      if (frame_start_i) begin img_width_i = 10'($urandom_range(0, 15)); img_height_i = 9'($urandom_range(0, 7)); end
      @(negedge clk);
      xfer = px_valid_i && px_ready_o;
      if (frame_done_o) finished = 1;
      if (start_o && since < 0) since = 0;
      else if (since >= 0) since++;
      if (rst_after >= 0 && since == rst_after) begin
        @(posedge clk); #1;
        px_valid_i = 1'b0; frame_start_i = 1'b0;
        reset_i = 1'b1;
        #1;
        chk("async_rst_start", start_o, 0);
        chk("async_rst_gray", px_gray_o, 0);
        chk("async_rst_busy", busy_o, 0);
        @(negedge clk);
        @(posedge clk); #1;
        reset_i = 1'b0;
        finished = 1;
      end else begin
        @(posedge clk); #1;
        if (xfer) pi++;
        cyc++;
      end
    end
    frame_start_i = 1'b0;
    px_valid_i = 1'b0;
    if (rst_after < 0) chk("frame_completes", int'(finished), 1);
  endtask

  task automatic chk_cap(input string name, input int base, input int idx, input int v);
    if (base + idx < cap.size()) chk(name, cap[base + idx], v);
    else chk(name, -1, v);
  endtask

  initial begin
    int b0, s0, f0, d0;
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
    idle(4);

    // 3x3 raster 1..9
    set_img(3, 3, 0);
    b0 = cap.size(); s0 = n_start; f0 = n_fin;
    run_frame(3, 3, 0, -1, 0);
    chk("t1_len", cap.size() - b0, 9);
    for (int i = 0; i < 9; i++) chk_cap("t1_seq", b0, i, e33[i]);
    chk("t1_starts", n_start - s0, 1);
    chk("t1_done_after_finish", done_cyc - fin_cyc, 2);
    idle(3);

    // 4x3, value 10*row+col
    set_img(4, 3, 1);
    b0 = cap.size();
    run_frame(4, 3, 0, -1, 0);
    for (int i = 0; i < 12; i++) chk_cap("t2_seq", b0, i, e43[i]);
    chk("t2_finish_offset", fin_cyc - st_cyc, 14);
    idle(3);

    // 4x4, two bands
    set_img(4, 4, 1);
    b0 = cap.size(); s0 = n_start; f0 = n_fin;
    run_frame(4, 4, 0, -1, 0);
    chk("t3_len", cap.size() - b0, 24);
    for (int i = 0; i < 12; i++) chk_cap("t3_band0", b0, i, e43[i]);
    for (int i = 0; i < 12; i++) chk_cap("t3_band1", b0 + 12, i, e44[i]);
    chk("t3_starts", n_start - s0, 2);
    chk("t3_finishes", n_fin - f0, 2);
    idle(3);

    // 3x3 with valid on alternate cycles
    set_img(3, 3, 0);
    b0 = cap.size();
    run_frame(3, 3, 1, -1, 0);
    for (int i = 0; i < 9; i++) chk_cap("t4_seq", b0, i, e33[i]);
    idle(3);

    // reset in the middle of the first window
    s0 = n_start; f0 = n_fin; d0 = n_done;
    run_frame(3, 3, 0, 4, 0);
    idle(20);
    chk("t5_starts", n_start - s0, 1);
    chk("t5_finishes", n_fin - f0, 0);
    chk("t5_dones", n_done - d0, 0);
    b0 = cap.size();
    run_frame(3, 3, 0, -1, 0);
    for (int i = 0; i < 9; i++) chk_cap("t5_seq", b0, i, e33[i]);
    idle(3);

    // degenerate W=2, H=5
    s0 = n_start;
    run_frame(2, 5, 0, -1, 0);
    chk("t6_starts", n_start - s0, 0);
    chk("t6_done_latency", done_cyc - fs_cyc, 1);
    idle(3);

    // randomized frames with stalls and spurious frame_start
    for (int n = 0; n < 8; n++) begin
      int w, h;
      w = $urandom_range(3, 12);
      h = $urandom_range(3, 6);
      set_img(w, h, 2);
      s0 = n_start;
      run_frame(w, h, 2, -1, 1);
      chk("rand_bands", n_start - s0, h - 2);
      idle($urandom_range(1, 5));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
